// File: rtl/spi_reg_bridge.sv
// SPI mode-0 peripheral oversampled in clk that turns 1+ADDR_W+REG_W bit frames into register-bank accesses.
// Latency: ~SYNC_N+2 clk from SCLK edge to action; write strobe holds until ack, so a slow bank stalls in STROBE.
module spi_reg_bridge #(
    parameter int REG_W  = 8,
    parameter int ADDR_W = 8,
    parameter int SYNC_N = 2
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              ena,
    input  logic              spi_cs_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_rdn,
    output logic [ADDR_W-1:0] addr,
    output logic [REG_W-1:0]  wdata,
    output logic              we,
    input  logic [REG_W-1:0]  rdata,
    input  logic              ack,
    input  logic              err,
    output logic              txn_err
);

    localparam int FRAME_W = 1 + ADDR_W + REG_W;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STROBE, DONE} state_t;

    state_t             state, state_nxt;
    logic [SYNC_N-1:0]  cs_sh, sclk_sh, mosi_sh;
    logic               cs_d, sclk_d;
    logic               cs_s, sclk_s, mosi_s;
    logic               rise, fall, cs_fall;
    logic               in_frame, abort;
    logic [CNT_W-1:0]   bit_cnt, cnt_inc;
    logic               last_addr_bit, last_bit;
    logic [REG_W-2:0]   hold;
    logic [REG_W-1:0]   hold_nxt;
    logic [REG_W-2:0]   tx;
    logic               load_pend;

    // Synchroniser chains; CS idles high so it resets to 1 to avoid a false falling edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cs_sh   <= '1;
            sclk_sh <= '0;
            mosi_sh <= '0;
            cs_d    <= 1'b1;
            sclk_d  <= 1'b0;
        end else begin
            cs_sh   <= {cs_sh[SYNC_N-2:0], spi_cs_n};
            sclk_sh <= {sclk_sh[SYNC_N-2:0], spi_sclk};
            mosi_sh <= {mosi_sh[SYNC_N-2:0], spi_mosi};
            cs_d    <= cs_sh[SYNC_N-1];
            sclk_d  <= sclk_sh[SYNC_N-1];
        end
    end

    assign cs_s    = cs_sh[SYNC_N-1];
    assign sclk_s  = sclk_sh[SYNC_N-1];
    assign mosi_s  = mosi_sh[SYNC_N-1];
    assign rise    = sclk_s & ~sclk_d;
    assign fall    = ~sclk_s & sclk_d;
    assign cs_fall = ~cs_s & cs_d;

    assign in_frame      = (state == CMD) || (state == ADDR) || (state == DATA);
    assign abort         = in_frame && (cs_s || !ena);
    assign cnt_inc       = (bit_cnt == CNT_W'(FRAME_W)) ? bit_cnt : bit_cnt + CNT_W'(1);
    assign last_addr_bit = (bit_cnt == CNT_W'(ADDR_W));
    assign last_bit      = (bit_cnt == CNT_W'(FRAME_W - 1));
    assign hold_nxt      = {hold, mosi_s};
    assign spi_miso_oe   = ena & ~cs_s;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (ena && cs_fall) state_nxt = CMD;
            CMD:    if (abort) state_nxt = IDLE;
                    else if (rise) state_nxt = ADDR;
            ADDR:   if (abort) state_nxt = IDLE;
                    else if (rise && last_addr_bit) state_nxt = DATA;
            DATA:   if (abort) state_nxt = IDLE;
                    else if (rise && last_bit) state_nxt = wr_rdn ? STROBE : DONE;
            STROBE: if (ack) state_nxt = DONE;
            DONE:   if (cs_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        we      = (state == STROBE);
        txn_err = abort || ((state == STROBE) && ack && err);
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            bit_cnt   <= '0;
            wr_rdn    <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            hold      <= '0;
            tx        <= '0;
            spi_miso  <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            case (state)
                IDLE: bit_cnt <= '0;
                CMD: if (!abort && rise) begin
                    wr_rdn  <= mosi_s;
                    bit_cnt <= cnt_inc;
                end
                ADDR: if (!abort && rise) begin
                    addr    <= {addr[ADDR_W-2:0], mosi_s};
                    bit_cnt <= cnt_inc;
                    if (last_addr_bit && !wr_rdn) load_pend <= 1'b1;
                end
                DATA: if (!abort) begin
                    // Bit 7 goes out on load; the fall right after the last address bit must not shift it away.
                    if (load_pend) begin
                        tx       <= rdata[REG_W-2:0];
                        spi_miso <= rdata[REG_W-1];
                    end else if (fall && !wr_rdn && bit_cnt > CNT_W'(ADDR_W + 1)) begin
                        tx       <= tx << 1;
                        spi_miso <= tx[REG_W-2];
                    end
                    if (rise) begin
                        bit_cnt <= cnt_inc;
                        if (wr_rdn) begin
                            hold <= hold_nxt[REG_W-2:0];
                            if (last_bit) wdata <= hold_nxt;
                        end
                    end
                end
                default: ;
            endcase
            if (state_nxt != DATA) spi_miso <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: drives SPI frames at 16 clk per SCLK and checks bank-side and MISO results.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rstb, ena, spi_cs_n, spi_sclk, spi_mosi;
    logic       spi_miso, spi_miso_oe, wr_rdn, we, ack, err, txn_err;
    logic [7:0] addr, wdata, rdata;

    int checks = 0;
    int errors = 0;

    int         we_cyc = 0, terr_cnt = 0, terr_aligned = 0, oe_cyc = 0;
    logic [7:0] cap_addr = 8'h00, cap_wdata = 8'h00;
    logic       cap_wr_rdn = 1'b0;

    always #5 clk = ~clk;

    spi_reg_bridge #(.REG_W(8), .ADDR_W(8), .SYNC_N(2)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
        .wr_rdn(wr_rdn), .addr(addr), .wdata(wdata), .we(we),
        .rdata(rdata), .ack(ack), .err(err), .txn_err(txn_err)
    );

    // Bench register bank: one fixed status value, everything else returns inverted address.
    assign rdata = (addr == 8'h83) ? 8'h3C : ~addr;

    always @(negedge clk) begin
        if (rstb) begin
            if (we) begin
                we_cyc++;
                cap_addr   = addr;
                cap_wdata  = wdata;
                cap_wr_rdn = wr_rdn;
            end
            if (txn_err) begin
                terr_cnt++;
                if (we && ack) terr_aligned++;
            end
            if (spi_miso_oe) oe_cyc++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b, output logic miso_at_rise);
        spi_mosi = b;
        repeat (8) @(negedge clk);
        miso_at_rise = spi_miso;
        spi_sclk = 1'b1;
        repeat (8) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    // Sends the first nbits of frame, returns MISO seen at data-phase rises, then leaves CS high for one SCLK period.
    task automatic spi_xfer(input logic [16:0] frame, input int nbits, output logic [7:0] rx);
        logic m;
        logic [16:0] f;
        f  = frame;
        rx = 8'h00;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            send_bit(f[16-i], m);
            if (i >= 9 && i < 17) rx = {rx[6:0], m};
        end
        repeat (8) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        int we0, te0, ta0, oe0;
        logic [7:0] rx;
        logic m;

        rstb = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
        ack = 1'b1; err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_miso", 32'(spi_miso), 0);
        chk("rst_oe", 32'(spi_miso_oe), 0);
        chk("rst_wr_rdn", 32'(wr_rdn), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_wdata", 32'(wdata), 0);
        chk("rst_we", 32'(we), 0);
        chk("rst_txn_err", 32'(txn_err), 0);
        rstb = 1'b1;
        repeat (4) @(negedge clk);

        // Plain write 0x03 <- 0xA5
        we0 = we_cyc; te0 = terr_cnt;
        spi_xfer({1'b1, 8'h03, 8'hA5}, 17, rx);
        chk("wr_we_count", 32'(we_cyc - we0), 1);
        chk("wr_addr", 32'(cap_addr), 32'h03);
        chk("wr_wdata", 32'(cap_wdata), 32'hA5);
        chk("wr_wr_rdn", 32'(cap_wr_rdn), 1);
        chk("wr_txn_err", 32'(terr_cnt - te0), 0);

        // Read of status register 0x83
        we0 = we_cyc; te0 = terr_cnt;
        spi_xfer({1'b0, 8'h83, 8'h00}, 17, rx);
        chk("rd_miso_bits", 32'(rx), 32'h3C);
        chk("rd_we_count", 32'(we_cyc - we0), 0);
        chk("rd_wr_rdn", 32'(wr_rdn), 0);
        chk("rd_addr_hold", 32'(addr), 32'h83);
        chk("rd_miso_idle", 32'(spi_miso), 0);
        chk("rd_oe_cs_high", 32'(spi_miso_oe), 0);
        chk("rd_txn_err", 32'(terr_cnt - te0), 0);

        // Abort after 10 bits of a write
        we0 = we_cyc; te0 = terr_cnt;
        spi_xfer({1'b1, 8'h07, 8'h99}, 10, rx);
        chk("abort_we_count", 32'(we_cyc - we0), 0);
        chk("abort_txn_err", 32'(terr_cnt - te0), 1);
        chk("abort_wdata", 32'(wdata), 32'hA5);
        we0 = we_cyc; te0 = terr_cnt;
        spi_xfer({1'b1, 8'h05, 8'h5A}, 17, rx);
        chk("post_abort_we", 32'(we_cyc - we0), 1);
        chk("post_abort_addr", 32'(cap_addr), 32'h05);
        chk("post_abort_wdata", 32'(cap_wdata), 32'h5A);
        chk("post_abort_terr", 32'(terr_cnt - te0), 0);

        // Block disabled: whole write frame ignored
        ena = 1'b0;
        we0 = we_cyc; te0 = terr_cnt; oe0 = oe_cyc;
        spi_xfer({1'b1, 8'h10, 8'hFF}, 17, rx);
        chk("ena0_we", 32'(we_cyc - we0), 0);
        chk("ena0_oe", 32'(oe_cyc - oe0), 0);
        chk("ena0_txn_err", 32'(terr_cnt - te0), 0);
        chk("ena0_state", 32'(dut.state), 0);
        chk("ena0_wdata", 32'(wdata), 32'h5A);
        ena = 1'b1;
        repeat (4) @(negedge clk);

        // Reset mid-address
        we0 = we_cyc;
        spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) send_bit(i[0], m);
        rstb = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_addr", 32'(addr), 0);
        chk("mid_rst_wdata", 32'(wdata), 0);
        chk("mid_rst_wr_rdn", 32'(wr_rdn), 0);
        chk("mid_rst_we", 32'(we), 0);
        chk("mid_rst_oe", 32'(spi_miso_oe), 0);
        chk("mid_rst_miso", 32'(spi_miso), 0);
        chk("mid_rst_txn_err", 32'(txn_err), 0);
        spi_cs_n = 1'b1; spi_sclk = 1'b0;
        repeat (4) @(negedge clk);
        rstb = 1'b1;
        repeat (16) @(negedge clk);
        chk("mid_rst_no_we", 32'(we_cyc - we0), 0);
        spi_xfer({1'b1, 8'h01, 8'h7E}, 17, rx);
        chk("after_rst_we", 32'(we_cyc - we0), 1);
        chk("after_rst_addr", 32'(cap_addr), 32'h01);
        chk("after_rst_wdata", 32'(cap_wdata), 32'h7E);

        // Back-to-back: errored write then read, one SCLK of CS high between them
        we0 = we_cyc; te0 = terr_cnt; ta0 = terr_aligned;
        err = 1'b1;
        spi_xfer({1'b1, 8'h20, 8'h11}, 17, rx);
        err = 1'b0;
        chk("b2b_wr_we", 32'(we_cyc - we0), 1);
        chk("b2b_wr_addr", 32'(cap_addr), 32'h20);
        chk("b2b_wr_wdata", 32'(cap_wdata), 32'h11);
        chk("b2b_err_pulse", 32'(terr_cnt - te0), 1);
        chk("b2b_err_aligned", 32'(terr_aligned - ta0), 1);
        spi_xfer({1'b0, 8'h42, 8'h00}, 17, rx);
        chk("b2b_rd_data", 32'(rx), 32'hBD);
        chk("b2b_rd_addr", 32'(addr), 32'h42);
        chk("b2b_rd_no_we", 32'(we_cyc - we0), 1);
        chk("b2b_rd_no_err", 32'(terr_cnt - te0), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
